// File: rtl/exception_unit.sv
// Fixed-priority exception/interrupt arbiter with pending flags, valid/ready
// hand-off to trap entry, and nesting-depth based double/triple fault escalation.
module exception_unit #(
    parameter int                     NUM_SOURCES  = 16,
    parameter int                     CAUSE_W      = 8,
    parameter logic [NUM_SOURCES-1:0] SYNC_MASK    = NUM_SOURCES'(16'h04FE),
    parameter int                     DOUBLE_CAUSE = 8,
    parameter int                     MAX_NEST     = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_SOURCES-1:0]           raise_i,
    input  logic [NUM_SOURCES-1:0]           mask_i,
    output logic                             exc_valid_o,
    output logic [CAUSE_W-1:0]               exc_cause_o,
    input  logic                             exc_ready_i,
    input  logic                             exc_ret_i,
    output logic [$clog2(MAX_NEST+1)-1:0]    depth_o,
    output logic [NUM_SOURCES-1:0]           pending_o,
    output logic                             cpu_reset_o
);

    localparam int DW = $clog2(MAX_NEST + 1);
    localparam int IW = $clog2(NUM_SOURCES);
    // Codes 0, 8 and 9 are not real sources and can never become pending.
    localparam logic [NUM_SOURCES-1:0] RESERVED = NUM_SOURCES'(16'h0301);

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        TRAP_RESET
    } state_t;

    state_t                 state, state_next;
    logic [NUM_SOURCES-1:0] pending, pending_next;
    logic [NUM_SOURCES-1:0] eligible, clear;
    logic [DW-1:0]          depth, depth_next;
    logic [CAUSE_W-1:0]     cause, cause_next;
    logic [IW-1:0]          src, src_next, sel;
    logic                   any, handshake, sel_sync;

    // Asynchronous sources are only taken outside any handler.
    assign eligible  = pending & (SYNC_MASK | ((depth == '0) ? mask_i : '0));
    assign handshake = (state == OFFER) && exc_ready_i;
    assign sel_sync  = SYNC_MASK[sel];

    always_comb begin
        any = 1'b0;
        sel = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                any = 1'b1;
                sel = IW'(i);
            end
        end
    end

    always_comb begin
        state_next = state;
        cause_next = cause;
        src_next   = src;
        clear      = '0;
        unique case (state)
            IDLE: begin
                if (any) begin
                    if (sel_sync && depth == DW'(MAX_NEST)) begin
                        state_next = TRAP_RESET;
                    end else begin
                        state_next = OFFER;
                        src_next   = sel;
                        if (sel_sync && depth == DW'(MAX_NEST - 1) && depth != '0)
                            cause_next = CAUSE_W'(DOUBLE_CAUSE);
                        else
                            cause_next = CAUSE_W'(sel);
                    end
                end
            end
            OFFER: begin
                if (exc_ready_i) begin
                    state_next = IDLE;
                    clear      = NUM_SOURCES'(1) << src;
                end
            end
            TRAP_RESET: state_next = IDLE;
            default:    state_next = IDLE;
        endcase

        depth_next = depth;
        if (state == TRAP_RESET)
            depth_next = '0;
        else if (handshake && !exc_ret_i)
            depth_next = depth + DW'(1);
        else if (!handshake && exc_ret_i && depth != '0)
            depth_next = depth - DW'(1);

        // A raise in the same cycle as its clear wins; a triple fault drops everything.
        if (state == TRAP_RESET)
            pending_next = '0;
        else
            pending_next = (pending & ~clear) | (raise_i & ~RESERVED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            depth   <= '0;
            cause   <= '0;
            src     <= '0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            depth   <= depth_next;
            cause   <= cause_next;
            src     <= src_next;
        end
    end

    assign exc_valid_o = (state == OFFER);
    assign exc_cause_o = (state == OFFER) ? cause : '0;
    assign cpu_reset_o = (state == TRAP_RESET);
    assign depth_o     = depth;
    assign pending_o   = pending;

endmodule

// File: tb/tb_exception_unit.sv
// Bench for exception_unit: directed scenarios with hand-derived expectations
// plus randomized traffic checked against a transaction-level model.
module tb_exception_unit;

    localparam logic [15:0] SYNC     = 16'h04FE;
    localparam logic [15:0] USABLE   = 16'hFCFE;
    localparam int          MAX_NEST = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] raise_i;
    logic [15:0] mask_i;
    logic        exc_valid_o;
    logic [7:0]  exc_cause_o;
    logic        exc_ready_i;
    logic        exc_ret_i;
    logic [1:0]  depth_o;
    logic [15:0] pending_o;
    logic        cpu_reset_o;

    int n_vec = 0;
    int n_bad = 0;

    logic [15:0] m_pend;
    int          m_depth;
    bit          m_offer;
    bit          m_trap;
    int          m_cause;
    int          m_src;

    exception_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .raise_i     (raise_i),
        .mask_i      (mask_i),
        .exc_valid_o (exc_valid_o),
        .exc_cause_o (exc_cause_o),
        .exc_ready_i (exc_ready_i),
        .exc_ret_i   (exc_ret_i),
        .depth_o     (depth_o),
        .pending_o   (pending_o),
        .cpu_reset_o (cpu_reset_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        raise_i     = '0;
        mask_i      = '0;
        exc_ready_i = 1'b0;
        exc_ret_i   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [27:0] obs();
        return {exc_valid_o, exc_cause_o, depth_o, cpu_reset_o, pending_o};
    endfunction

    function automatic int pick(input logic [15:0] p, input logic [15:0] m, input int d);
        for (int i = 0; i < 16; i++)
            if (p[i] && (SYNC[i] || (m[i] && d == 0)))
                return i;
        return -1;
    endfunction

    // Predicts the state after the coming clock edge from the current inputs.
    task automatic model_step();
        int          p;
        bit          hs;
        logic [15:0] clr;
        if (!rst_n) begin
            m_pend = '0; m_depth = 0; m_offer = 0; m_trap = 0; m_cause = 0; m_src = 0;
            return;
        end
        if (m_trap) begin
            m_pend = '0; m_depth = 0; m_trap = 0;
            return;
        end
        hs  = m_offer && exc_ready_i;
        clr = '0;
        if (hs) begin
            clr[m_src] = 1'b1;
            m_offer    = 0;
        end else if (!m_offer) begin
            p = pick(m_pend, mask_i, m_depth);
            if (p >= 0) begin
                if (SYNC[p] && m_depth == MAX_NEST) begin
                    m_trap = 1;
                end else begin
                    m_offer = 1;
                    m_src   = p;
                    m_cause = (SYNC[p] && m_depth == MAX_NEST - 1) ? 8 : p;
                end
            end
        end
        if (hs && !exc_ret_i)
            m_depth++;
        else if (!hs && exc_ret_i && m_depth > 0)
            m_depth--;
        m_pend = (m_pend & ~clr) | (raise_i & USABLE);
    endtask

    task automatic test_reset();
        idle_inputs();
        raise_i = 16'hFFFF;
        rst_n   = 1'b0;
        tick();
        tick();
        n_vec++;
        if (obs() !== 28'h0) begin
            n_bad++; $display("FAIL reset_hold: got %h want %h", obs(), 28'h0);
        end
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (obs() !== 28'h0) begin
            n_bad++; $display("FAIL reset_release: got %h want %h", obs(), 28'h0);
        end
        tick();
        n_vec++;
        if (obs() !== {1'b0, 8'd0, 2'd0, 1'b0, 16'hFCFE}) begin
            n_bad++; $display("FAIL reset_pending: got %h want %h", obs(), {1'b0, 8'd0, 2'd0, 1'b0, 16'hFCFE});
        end
        raise_i = '0;
        tick();
        n_vec++;
        if (obs() !== {1'b1, 8'd1, 2'd0, 1'b0, 16'hFCFE}) begin
            n_bad++; $display("FAIL reset_offer: got %h want %h", obs(), {1'b1, 8'd1, 2'd0, 1'b0, 16'hFCFE});
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (obs() !== 28'h0) begin
            n_bad++; $display("FAIL reset_abandon: got %h want %h", obs(), 28'h0);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_priority();
        logic [27:0] exp [5];
        string       nm  [5];
        do_reset();
        exc_ready_i = 1'b1;
        raise_i     = 16'h0024;
        exp[0] = {1'b0, 8'd0, 2'd0, 1'b0, 16'h0024}; nm[0] = "prio_idle";
        exp[1] = {1'b1, 8'd2, 2'd0, 1'b0, 16'h0024}; nm[1] = "prio_first";
        exp[2] = {1'b0, 8'd0, 2'd1, 1'b0, 16'h0020}; nm[2] = "prio_gap";
        // Bit 5 is synchronous and now arrives inside a handler: escalated.
        exp[3] = {1'b1, 8'd8, 2'd1, 1'b0, 16'h0020}; nm[3] = "prio_second";
        exp[4] = {1'b0, 8'd0, 2'd2, 1'b0, 16'h0000}; nm[4] = "prio_done";
        for (int k = 0; k < 5; k++) begin
            tick();
            raise_i = '0;
            n_vec++;
            if (obs() !== exp[k]) begin
                n_bad++; $display("FAIL %s: got %h want %h", nm[k], obs(), exp[k]);
            end
        end
        exc_ready_i = 1'b0;
    endtask

    task automatic test_masking();
        do_reset();
        raise_i = 16'h0800;
        tick();
        raise_i = '0;
        tick();
        tick();
        n_vec++;
        if (obs() !== {1'b0, 8'd0, 2'd0, 1'b0, 16'h0800}) begin
            n_bad++; $display("FAIL mask_blocked: got %h want %h", obs(), {1'b0, 8'd0, 2'd0, 1'b0, 16'h0800});
        end
        mask_i = 16'h0800;
        tick();
        n_vec++;
        if (obs() !== {1'b1, 8'd11, 2'd0, 1'b0, 16'h0800}) begin
            n_bad++; $display("FAIL mask_offer: got %h want %h", obs(), {1'b1, 8'd11, 2'd0, 1'b0, 16'h0800});
        end
        exc_ready_i = 1'b1;
        tick();
        exc_ready_i = 1'b0;
        raise_i     = 16'h0800;
        tick();
        raise_i = '0;
        tick();
        tick();
        n_vec++;
        if (obs() !== {1'b0, 8'd0, 2'd1, 1'b0, 16'h0800}) begin
            n_bad++; $display("FAIL mask_nested: got %h want %h", obs(), {1'b0, 8'd0, 2'd1, 1'b0, 16'h0800});
        end
        exc_ret_i = 1'b1;
        tick();
        exc_ret_i = 1'b0;
        n_vec++;
        if (obs() !== {1'b0, 8'd0, 2'd0, 1'b0, 16'h0800}) begin
            n_bad++; $display("FAIL mask_ret: got %h want %h", obs(), {1'b0, 8'd0, 2'd0, 1'b0, 16'h0800});
        end
        tick();
        n_vec++;
        if (obs() !== {1'b1, 8'd11, 2'd0, 1'b0, 16'h0800}) begin
            n_bad++; $display("FAIL mask_after_ret: got %h want %h", obs(), {1'b1, 8'd11, 2'd0, 1'b0, 16'h0800});
        end
        exc_ready_i = 1'b1;
        tick();
        idle_inputs();
        n_vec++;
        if (obs() !== {1'b0, 8'd0, 2'd1, 1'b0, 16'h0000}) begin
            n_bad++; $display("FAIL mask_accept: got %h want %h", obs(), {1'b0, 8'd0, 2'd1, 1'b0, 16'h0000});
        end
    endtask

    task automatic test_double_fault();
        do_reset();
        raise_i = 16'h0010;
        tick();
        raise_i = '0;
        tick();
        n_vec++;
        if (obs() !== {1'b1, 8'd4, 2'd0, 1'b0, 16'h0010}) begin
            n_bad++; $display("FAIL df_first: got %h want %h", obs(), {1'b1, 8'd4, 2'd0, 1'b0, 16'h0010});
        end
        exc_ready_i = 1'b1;
        tick();
        exc_ready_i = 1'b0;
        raise_i     = 16'h0008;
        tick();
        raise_i = '0;
        tick();
        n_vec++;
        if (obs() !== {1'b1, 8'd8, 2'd1, 1'b0, 16'h0008}) begin
            n_bad++; $display("FAIL df_offer: got %h want %h", obs(), {1'b1, 8'd8, 2'd1, 1'b0, 16'h0008});
        end
        exc_ready_i = 1'b1;
        tick();
        exc_ready_i = 1'b0;
        n_vec++;
        if (obs() !== {1'b0, 8'd0, 2'd2, 1'b0, 16'h0000}) begin
            n_bad++; $display("FAIL df_accept: got %h want %h", obs(), {1'b0, 8'd0, 2'd2, 1'b0, 16'h0000});
        end
    endtask

    task automatic test_triple_fault();
        raise_i = 16'h0002;
        tick();
        raise_i = '0;
        n_vec++;
        if (obs() !== {1'b0, 8'd0, 2'd2, 1'b0, 16'h0002}) begin
            n_bad++; $display("FAIL tf_pending: got %h want %h", obs(), {1'b0, 8'd0, 2'd2, 1'b0, 16'h0002});
        end
        tick();
        n_vec++;
        if (obs() !== {1'b0, 8'd0, 2'd2, 1'b1, 16'h0002}) begin
            n_bad++; $display("FAIL tf_pulse: got %h want %h", obs(), {1'b0, 8'd0, 2'd2, 1'b1, 16'h0002});
        end
        raise_i = 16'h0004;
        tick();
        raise_i = '0;
        n_vec++;
        if (obs() !== 28'h0) begin
            n_bad++; $display("FAIL tf_after: got %h want %h", obs(), 28'h0);
        end
        tick();
        n_vec++;
        if (obs() !== 28'h0) begin
            n_bad++; $display("FAIL tf_quiet: got %h want %h", obs(), 28'h0);
        end
    endtask

    task automatic test_backpressure();
        logic [27:0] e;
        do_reset();
        raise_i = 16'h0040;
        tick();
        raise_i = '0;
        tick();
        for (int k = 0; k < 6; k++) begin
            e = {1'b1, 8'd6, 2'd0, 1'b0, (k >= 2) ? 16'h0042 : 16'h0040};
            n_vec++;
            if (obs() !== e) begin
                n_bad++; $display("FAIL bp_hold%0d: got %h want %h", k, obs(), e);
            end
            raise_i = (k == 1) ? 16'h0002 : 16'h0000;
            tick();
        end
        exc_ready_i = 1'b1;
        exc_ret_i   = 1'b1;
        raise_i     = 16'h0040;
        tick();
        idle_inputs();
        n_vec++;
        if (obs() !== {1'b0, 8'd0, 2'd0, 1'b0, 16'h0042}) begin
            n_bad++; $display("FAIL ret_hs_reraise: got %h want %h", obs(), {1'b0, 8'd0, 2'd0, 1'b0, 16'h0042});
        end
        tick();
        n_vec++;
        if (obs() !== {1'b1, 8'd1, 2'd0, 1'b0, 16'h0042}) begin
            n_bad++; $display("FAIL bp_next: got %h want %h", obs(), {1'b1, 8'd1, 2'd0, 1'b0, 16'h0042});
        end
        exc_ready_i = 1'b1;
        tick();
        exc_ready_i = 1'b0;
        n_vec++;
        if (obs() !== {1'b0, 8'd0, 2'd1, 1'b0, 16'h0040}) begin
            n_bad++; $display("FAIL bp_accept: got %h want %h", obs(), {1'b0, 8'd0, 2'd1, 1'b0, 16'h0040});
        end
    endtask

    task automatic test_random();
        logic [27:0] e;
        do_reset();
        rst_n = 1'b0;
        model_step();
        rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rst_n       = ($urandom_range(0, 299) != 0);
            raise_i     = 16'($urandom & $urandom & $urandom);
            mask_i      = 16'($urandom);
            exc_ready_i = 1'($urandom_range(0, 1));
            exc_ret_i   = ($urandom_range(0, 5) == 0);
            model_step();
            tick();
            e = {m_offer, m_offer ? 8'(m_cause) : 8'd0, 2'(m_depth), m_trap, m_pend};
            n_vec++;
            if (obs() !== e) begin
                n_bad++; $display("FAIL rand_cyc%0d: got %h want %h", c, obs(), e);
            end
        end
        rst_n = 1'b1;
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_priority();
        test_masking();
        test_double_fault();
        test_triple_fault();
        test_backpressure();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
